// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int N_DEFAULT = 8;

    // Wide all-ones source; the top slices the 2N-bit divide-by-zero quotient from it.
    localparam logic [63:0] DIV0_ONES = '1;

    // Step counter width for a 2N-step division.
    function automatic int count_width(input int n);
        return $clog2(2 * n + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [N-1:0] rem,
    input  logic         msb,
    input  logic [N-1:0] y,
    output logic [N-1:0] rem_next,
    output logic         qbit
);

    logic [N:0] trial;

    // A successful subtraction leaves a result below y, so the low N bits suffice.
    always_comb begin
        trial    = {rem, msb};
        qbit     = (trial >= {1'b0, y});
        rem_next = qbit ? (trial[N-1:0] - y) : trial[N-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, 2N-bit dividend by N-bit divisor, one quotient bit per clock.
// Optional SEQ_DIVIDER_EXACT_EN drives the exact flag; otherwise exact is tied low.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] Z,
    input  logic [N-1:0]   Y,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] Q,
    output logic [N-1:0]   R,
    output logic           div0,
    output logic           ovf,
    output logic           exact
);

    localparam int            CW   = count_width(N);
    localparam logic [CW-1:0] LAST = CW'(2 * N - 1);

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] dvd;
    logic [N-1:0]   rem;
    logic [N-1:0]   ysh;
    logic [N-1:0]   rem_next;
    logic           qbit;
    logic [2*N-1:0] q_final;
    logic           accept;
    logic           zero_div;
    logic           last_step;
    logic           ovf_next;

    assign accept    = start && (state != RUN);
    assign zero_div  = accept && (Y == '0);
    assign last_step = (state == RUN) && (cnt == LAST);
    assign q_final   = {dvd[2*N-2:0], qbit};
    assign ovf_next  = |q_final[2*N-1:N];

    div_step #(.N(N)) u_step (
        .rem      (rem),
        .msb      (dvd[2*N-1]),
        .y        (ysh),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) state_next = (Y == '0) ? DONE : RUN;
                else       state_next = IDLE;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            cnt <= '0;
        else if (state == RUN) cnt <= cnt + 1'b1;
        else                   cnt <= '0;
    end

    // Working registers carry no reset; an accepted start always reloads them.
    always_ff @(posedge clk) begin
        if (state != RUN) begin
            if (start) begin
                dvd <= Z;
                ysh <= Y;
                rem <= '0;
            end
        end else begin
            dvd <= q_final;
            rem <= rem_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q    <= '0;
            R    <= '0;
            div0 <= 1'b0;
            ovf  <= 1'b0;
        end else if (zero_div) begin
            Q    <= DIV0_ONES[2*N-1:0];
            R    <= '0;
            div0 <= 1'b1;
            ovf  <= 1'b0;
        end else if (last_step) begin
            Q    <= q_final;
            R    <= rem_next;
            div0 <= 1'b0;
            ovf  <= ovf_next;
        end
    end

`ifdef SEQ_DIVIDER_EXACT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         exact <= 1'b0;
        else if (zero_div)  exact <= 1'b0;
        else if (last_step) exact <= (rem_next == '0) && !ovf_next;
    end
`else
    assign exact = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, factor sweep and handshake corner cases.
module tb_seq_divider;

    localparam int N = 8;
`ifdef SEQ_DIVIDER_EXACT_EN
    localparam bit EXACT = 1'b1;
`else
    localparam bit EXACT = 1'b0;
`endif

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic [2*N-1:0] Z     = '0;
    logic [N-1:0]   Y     = '0;
    logic           busy, done, div0, ovf, exact;
    logic [2*N-1:0] Q;
    logic [N-1:0]   R;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        bit          d0;
        bit          ov;
        bit          ex;
    } res_t;

    typedef struct {
        logic [15:0] z;
        logic [7:0]  y;
        logic [15:0] q;
        logic [7:0]  r;
        bit          d0;
        bit          ov;
    } vec_t;

    res_t sb[$];
    vec_t vt[8];

    always #5 clk = ~clk;

    seq_divider #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .Z     (Z),
        .Y     (Y),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .div0  (div0),
        .ovf   (ovf),
        .exact (exact)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic res_t mk(input logic [15:0] q, input logic [7:0] r, input bit d0, input bit ov);
        res_t e;
        e.q  = q;
        e.r  = r;
        e.d0 = d0;
        e.ov = ov;
        e.ex = EXACT && (r == 0) && !ov && !d0;
        return e;
    endfunction

    // Call at a negedge: start is sampled on the next posedge, then inputs are scrambled.
    task automatic issue(input logic [15:0] z, input logic [7:0] y, input res_t e);
        Z = z;
        Y = y;
        start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        Z = 16'($urandom);
        Y = 8'($urandom);
    endtask

    task automatic finish_op(input bit is_div0, input int n0);
        int          n;
        bit          bseen;
        bit          held;
        logic [15:0] q0;
        res_t        e;
        n     = n0;
        bseen = busy;
        held  = 1'b1;
        q0    = Q;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) bseen = 1'b1;
            if (!done && Q !== q0) held = 1'b0;
        end
        check("done_seen", done, 1);
        check("latency", n, is_div0 ? 1 : 17);
        check("busy_seen", bseen, !is_div0);
        check("q_hold", held, 1);
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("Q", Q, e.q);
            check("R", R, e.r);
            check("div0", div0, e.d0);
            check("ovf", ovf, e.ov);
            check("exact", exact, e.ex);
        end
    endtask

    initial begin
        int x, y, cnt_done;

        vt[0] = '{16'd30000, 8'd150, 16'd200,   8'd0, 1'b0, 1'b0};
        vt[1] = '{16'd30001, 8'd150, 16'd200,   8'd1, 1'b0, 1'b0};
        vt[2] = '{16'hFFFF,  8'd1,   16'hFFFF,  8'd0, 1'b0, 1'b1};
        vt[3] = '{16'h1234,  8'd0,   16'hFFFF,  8'd0, 1'b1, 1'b0};
        vt[4] = '{16'd0,     8'd7,   16'd0,     8'd0, 1'b0, 1'b0};
        vt[5] = '{16'd65025, 8'd255, 16'd255,   8'd0, 1'b0, 1'b0};
        vt[6] = '{16'hFFFF,  8'd255, 16'd257,   8'd0, 1'b0, 1'b1};
        vt[7] = '{16'd100,   8'd7,   16'd14,    8'd2, 1'b0, 1'b0};

        #2 rst_n = 1'b0;
        #10;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_Q", Q, 0);
        check("rst_R", R, 0);
        check("rst_flags", {div0, ovf, exact}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table; each op starts in the previous done cycle, exercising back-to-back.
        for (int i = 0; i < 8; i++) begin
            issue(vt[i].z, vt[i].y, mk(vt[i].q, vt[i].r, vt[i].d0, vt[i].ov));
            finish_op(vt[i].d0, 1);
        end

        // Products of two N-bit factors divide back exactly.
        for (int i = 0; i < 200; i++) begin
            x = (i == 0) ? 255 : (i == 1) ? 1 : int'($urandom_range(1, 255));
            y = (i == 0) ? 255 : (i == 1) ? 1 : int'($urandom_range(1, 255));
            issue(16'(x * y), 8'(y), mk(16'(x), 8'd0, 1'b0, 1'b0));
            finish_op(1'b0, 1);
        end

        // Reset mid-run aborts; outputs clear without a clock and no done follows.
        issue(16'd100, 8'd7, mk(16'd14, 8'd2, 1'b0, 1'b0));
        finish_op(1'b0, 1);
        issue(16'd5000, 8'd7, mk(16'd714, 8'd2, 1'b0, 1'b0));
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_Q", Q, 0);
        check("abort_R", R, 0);
        check("abort_flags", {div0, ovf, exact}, 0);
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        cnt_done = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) cnt_done++;
        end
        check("abort_quiet", cnt_done, 0);
        issue(16'd30000, 8'd150, mk(16'd200, 8'd0, 1'b0, 1'b0));
        finish_op(1'b0, 1);

        // A start pulse while busy is dropped.
        repeat (2) @(negedge clk);
        issue(16'd1000, 8'd9, mk(16'd111, 8'd1, 1'b0, 1'b0));
        repeat (3) @(negedge clk);
        start = 1'b1;
        Z = 16'd5;
        Y = 8'd1;
        @(negedge clk);
        start = 1'b0;
        finish_op(1'b0, 5);
        cnt_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) cnt_done++;
        end
        check("no_queued_op", cnt_done, 0);

        // Explicit back-to-back pair: second start held through the first done cycle.
        issue(16'd30001, 8'd150, mk(16'd200, 8'd1, 1'b0, 1'b0));
        finish_op(1'b0, 1);
        check("b2b_in_done", done, 1);
        issue(16'd4321, 8'd33, mk(16'd130, 8'd31, 1'b0, 1'b0));
        finish_op(1'b0, 1);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative restoring divider, the inverse of the 8x8 Karatsuba multiplier. Takes a 2N-bit product-width dividend Z and an N-bit divisor Y and returns quotient Q and remainder R with Z = Q*Y + R. It recovers one factor of a product from the other and checks multiplier results in-system. It is multi-cycle, one quotient bit per clock, with a start/done handshake.

## Interface
- N, 8, factor width; dividend is 2N bits, matching the multiplier's Z.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only when busy=0.
- Z  in  2N  dividend; captured on the accepted start.
- Y  in  N  divisor; captured on the accepted start.
- busy  out  1  high while the division runs.
- done  out  1  one-cycle pulse; Q/R/flags valid from this cycle.
- Q  out  2N  quotient; held until the next done.
- R  out  N  remainder; held until the next done.
- div0  out  1  Y was 0 for the last operation.
- ovf  out  1  Q > 2^N-1, so Q is not an N-bit factor.
- exact  out  1  see Configuration.

## Operation
- FSM states:
  - IDLE: busy=0. start=1 captures Z and Y.
    - Y≠0: go to RUN, clear counter and partial remainder.
    - Y=0: go to DONE.
  - RUN: busy=1. One restoring step per cycle for 2N cycles, then DONE.
  - DONE: busy=0, done=1 for one cycle, then IDLE. start=1 here is accepted exactly as in IDLE.
- Restoring step, with rem being N+1 bits:
  - rem' = {rem[N-1:0], msb of dividend shift register}.
  - Shift the dividend register left one bit.
  - If rem' ≥ {1'b0,Y}: rem = rem' − Y and shift in quotient bit 1.
  - Else: rem = rem' and shift in quotient bit 0.
- Quotient bits are shifted into the vacated LSBs of the dividend register. After 2N steps that register holds Q and rem[N-1:0] holds R.
- Divide by zero: Q = all ones, R = 0, div0=1, ovf=0, exact=0.
- ovf = |Q[2N-1:N]. It is registered with Q.
- start while busy=1 is ignored; there is no queueing.
- Z and Y may change after acceptance without effect.

## Timing
- Reset values: busy=0, done=0, Q=0, R=0, div0=0, ovf=0, exact=0, FSM=IDLE, counter=0.
- Reset asserted mid-RUN aborts immediately. After release the block is IDLE with no done.
- Normal latency:
  - start high in cycle c.
  - busy high in cycles c+1 … c+2N.
  - done high in cycle c+2N+1 (cycle c+17 for N=8).
- Divide-by-zero latency: done high in cycle c+1, busy never rises.
- Q, R, div0, ovf and exact update only on the edge that enters DONE. They hold their value otherwise, including while busy.
- Back-to-back: start high during the done cycle d gives the next done at d+2N+1. Throughput is one result per 2N+1 cycles.

## Configuration
- SEQ_DIVIDER_EXACT_EN:
  - Defined: exact = (R==0) && !ovf && !div0, registered with Q. exact=1 means Z is exactly Y·X for an N-bit X = Q[N-1:0].
  - Undefined: the exact port remains and is tied to 0. No comparator logic is generated.

## Structure
- Package seq_divider_pkg holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - default N;
  - counter width $clog2(2N+1);
  - the divide-by-zero quotient constant (all ones).
- One sub-module, div_step: combinational single restoring iteration. Inputs are rem, dividend MSB and Y. Outputs are the next rem and the quotient bit. It is instantiated once in the top block.

## Test plan
- Z=16'h7530 (30000), Y=8'd150 → Q=200, R=0, ovf=0, exact=1 (with the macro), done in cycle c+17.
- Z=16'd30001, Y=8'd150 → Q=200, R=1, exact=0. Sweep all X,Y in 1..255 with Z=X*Y through the multiplier model → Q=X, R=0 for every pair.
- Z=16'hFFFF, Y=8'd1 → Q=16'hFFFF, R=0, ovf=1, exact=0.
- Z=16'h1234, Y=0 → done in cycle c+1, div0=1, Q=16'hFFFF, R=0, busy never high.
- Assert rst_n low at RUN step 5 → all outputs 0 asynchronously, no done after release. A new start then completes correctly.
- start pulsed while busy → ignored. start held during a done cycle → second result at d+17 with correct values. The first result stays held until then.
